// File: rtl/program_loader.sv
// program_loader: streams LEN bytes from a ready/valid byte source into RAM
// over the shared main bus. The CPU is held while a run is in progress. Each
// byte takes three cycles: handshake (WAIT), MAR load (ADDR), RAM write (DATA).
module program_loader #(
  parameter int LEN     = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              MI,
  output logic              RI,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] addr
);

  typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, FIN, ERR} state_t;

  state_t      state, next;
  logic [7:0]  byte_q;
  logic [31:0] timer;
  logic        tmo_hit;
  logic        last;

  // A zero TIMEOUT disables the idle watchdog.
  assign tmo_hit = (TIMEOUT > 0) && (timer == 32'(TIMEOUT - 1));
  assign last    = (addr == ADDR_W'(LEN - 1));

  // State register plus the address, timer, byte latch and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      timer  <= '0;
      byte_q <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (start) begin
          addr  <= '0;
          timer <= '0;
          done  <= 1'b0;
          error <= 1'b0;
        end
        WAIT: if (rx_valid) begin
          byte_q <= rx_data;
          timer  <= '0;
        end else begin
          timer  <= timer + 32'd1;
        end
        DATA: if (!last) addr <= addr + ADDR_W'(1);
        FIN:  done  <= 1'b1;
        ERR:  error <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and Moore output decode; outputs depend on state only.
  always_comb begin
    next     = state;
    rx_ready = 1'b0;
    bus_out  = 8'h00;
    bus_oe   = 1'b0;
    MI       = 1'b0;
    RI       = 1'b0;
    cpu_hold = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: if (start) next = WAIT;
      WAIT: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (rx_valid)     next = ADDR;
        else if (tmo_hit) next = ERR;
      end
      ADDR: begin
        bus_oe   = 1'b1;
        bus_out  = 8'(addr);
        MI       = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        next     = DATA;
      end
      DATA: begin
        bus_oe   = 1'b1;
        bus_out  = byte_q;
        RI       = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        next     = last ? FIN : WAIT;
      end
      FIN: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        next     = IDLE;
      end
      ERR: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. u0 has LEN=4, TIMEOUT=8; u1 has LEN=4,
// TIMEOUT=0. Both share the stimulus; u1 is used for the long-gap run.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic       rdy0, oe0, mi0, ri0, hold0, busy0, done0, err0;
  logic [7:0] bus0;
  logic [1:0] addr0;
  logic       rdy1, oe1, mi1, ri1, hold1, busy1, done1, err1;
  logic [7:0] bus1;
  logic [1:0] addr1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] mi_q[$];
  logic [7:0] ri_q[$];
  int         hs_q[$];

  program_loader #(.LEN(4), .ADDR_W(2), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy0), .bus_out(bus0), .bus_oe(oe0), .MI(mi0), .RI(ri0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0), .addr(addr0));

  program_loader #(.LEN(4), .ADDR_W(2), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy1), .bus_out(bus1), .bus_oe(oe1), .MI(mi1), .RI(ri1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1), .addr(addr1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offer one byte and wait (bounded) for the selected loader to take it.
  task automatic feed(input int which, input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (((which == 0) ? !rdy0 : !rdy1) && n < 20) begin
      tick();
      n++;
    end
    chk("feed_ready", {31'd0, (which == 0) ? rdy0 : rdy1}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  // Bus monitor for u0: log MAR loads, RAM writes and handshakes.
  always @(negedge clk) begin
    if (mi0) mi_q.push_back(bus0);
    if (ri0) ri_q.push_back(bus0);
    if (rx_valid && rdy0) hs_q.push_back(cyc);
    if (mi0 || ri0) begin
      chk("mi_ri_excl", {31'd0, mi0 & ri0}, 32'd0);
      chk("oe_with_strobe", {31'd0, oe0}, 32'd1);
    end
  end

  initial begin
    logic [7:0] b1 [4];
    b1[0] = 8'h1E; b1[1] = 8'h2F; b1[2] = 8'hE0; b1[3] = 8'hF0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_outs", {rdy0, oe0, mi0, ri0, hold0, busy0, done0, err0}, 32'd0);
    chk("rst_addr", {30'd0, addr0}, 32'd0);
    chk("rst_bus", {24'd0, bus0}, 32'd0);

    // Basic 4-byte load with rx_valid held high throughout
    start = 1'b1; tick(); start = 1'b0;
    chk("wait_outs", {rdy0, oe0, hold0, busy0}, 32'b1011);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int n;
      rx_data = b1[i];
      n = 0;
      while (!rdy0 && n < 20) begin tick(); n++; end
      chk("t1_ready", {31'd0, rdy0}, 32'd1);
      tick();
      chk("addr_state", {rdy0, mi0, ri0, oe0}, 32'b0101);
      chk("addr_bus", {24'd0, bus0}, i);
    end
    rx_valid = 1'b0;
    tick();
    chk("data_state", {rdy0, mi0, ri0, oe0}, 32'b0011);
    tick();
    chk("fin_state", {hold0, busy0, done0, rdy0}, 32'b1100);
    tick();
    chk("t1_after", {hold0, busy0, done0, err0}, 32'b0010);
    chk("t1_addr", {30'd0, addr0}, 32'd3);
    chk("t1_mi_n", mi_q.size(), 32'd4);
    chk("t1_ri_n", ri_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < mi_q.size()) chk("t1_mi_bus", {24'd0, mi_q[i]}, i);
      if (i < ri_q.size()) chk("t1_ri_bus", {24'd0, ri_q[i]}, {24'd0, b1[i]});
    end
    chk("t1_hs_n", hs_q.size(), 32'd4);
    for (int i = 1; i < 4; i++)
      if (i < hs_q.size()) chk("t1_hs_gap", hs_q[i] - hs_q[i-1], 32'd3);

    // Stray start pulses during WAIT and DATA are ignored
    mi_q.delete(); ri_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_done_clr", {31'd0, done0}, 32'd0);
    feed(0, 8'hA1);
    tick();
    chk("t2_in_data", {31'd0, ri0}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_addr_a", {30'd0, addr0}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_addr_b", {30'd0, addr0}, 32'd1);
    chk("t2_busy", {31'd0, busy0}, 32'd1);
    feed(0, 8'hB2); feed(0, 8'hC3); feed(0, 8'hD4);
    tick(); tick(); tick();
    chk("t2_done", {done0, err0, busy0}, 32'b100);
    chk("t2_mi_n", mi_q.size(), 32'd4);
    if (mi_q.size() == 4) chk("t2_mi_last", {24'd0, mi_q[3]}, 32'd3);
    if (ri_q.size() == 4) chk("t2_ri_0", {24'd0, ri_q[0]}, 32'hA1);
    if (ri_q.size() == 4) chk("t2_ri_3", {24'd0, ri_q[3]}, 32'hD4);

    // Timeout after two bytes (u0); u1 keeps waiting
    mi_q.delete(); ri_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    feed(0, 8'h11); feed(0, 8'h22);
    tick(); tick();
    chk("t3_wait_entry", {31'd0, rdy0}, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("t3_still_wait", {rdy0, err0}, 32'b10);
    tick();
    chk("t3_err_state", {rdy0, hold0, busy0, err0}, 32'b0110);
    tick();
    chk("t3_err_flags", {err0, done0, busy0, hold0}, 32'b1000);
    chk("t3_addr", {30'd0, addr0}, 32'd2);
    tick(); tick();
    chk("t3_mi_n", mi_q.size(), 32'd2);
    chk("t3_ri_n", ri_q.size(), 32'd2);

    // Long gap with the watchdog disabled (u1)
    for (int i = 0; i < 10000; i++) tick();
    chk("t4_gap", {busy1, err1, rdy1}, 32'b101);
    feed(1, 8'h33); feed(1, 8'h44);
    tick(); tick(); tick();
    chk("t4_done", {done1, err1, busy1}, 32'b100);
    chk("t4_addr", {30'd0, addr1}, 32'd3);
    chk("t4_u0_idle", {err0, busy0}, 32'b10);

    // Reset in the ADDR cycle of the third byte
    mi_q.delete(); ri_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    feed(0, 8'h55); feed(0, 8'h66); feed(0, 8'h77);
    chk("t5_in_addr", {mi0, bus0}, {1'b1, 8'h02});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_outs", {rdy0, oe0, mi0, ri0, hold0, busy0, done0, err0}, 32'd0);
    chk("t5_rst_addr", {30'd0, addr0}, 32'd0);
    chk("t5_rst_bus", {24'd0, bus0}, 32'd0);
    tick(); tick(); tick();
    chk("t5_no_ri", ri_q.size(), 32'd2);
    mi_q.delete(); ri_q.delete();
    start = 1'b1; tick(); start = 1'b0;
    feed(0, 8'h01); feed(0, 8'h02); feed(0, 8'h03); feed(0, 8'h04);
    tick(); tick(); tick();
    chk("t5_done", {done0, err0}, 32'b10);
    chk("t5_mi_n", mi_q.size(), 32'd4);
    if (mi_q.size() == 4) chk("t5_mi_first", {24'd0, mi_q[0]}, 32'd0);
    if (ri_q.size() == 4) chk("t5_ri_last", {24'd0, ri_q[3]}, 32'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The module SHALL have parameter LEN, default 16, meaning the number of bytes loaded per run (1..16).
REQ-002 The module SHALL have parameter ADDR_W, default 4, meaning the RAM address width.
REQ-003 The module SHALL have parameter TIMEOUT, default 1000000, meaning the maximum idle clk cycles between bytes (0 = no timeout).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a load run.
REQ-007 rx_valid  input  1  source byte available.
REQ-008 rx_data  input  8  source byte.
REQ-009 rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 bus_out  output  8  value the loader drives onto the main bus.
REQ-011 bus_oe  output  1  enables the loader's tri-state driver onto the main bus.
REQ-012 MI  output  1  memory-address-register load strobe to RAM.
REQ-013 RI  output  1  RAM write strobe.
REQ-014 cpu_hold  output  1  forces the CPU clock to stop (ORed with HLT at top level).
REQ-015 busy  output  1  load run in progress.
REQ-016 done  output  1  sticky: last run completed.
REQ-017 error  output  1  sticky: last run aborted on timeout.
REQ-018 addr  output  ADDR_W  RAM address currently being written.

Function
REQ-019 All outputs SHALL be Moore outputs decoded from registered state; no combinational path from any input to any output.
REQ-020 States SHALL be IDLE, WAIT, ADDR, DATA, FIN, ERR.
REQ-021 IDLE: rx_ready, bus_oe, MI, RI, cpu_hold and busy SHALL all be 0.
REQ-022 IDLE with start=1: go to WAIT; clear addr, timer, done and error.
REQ-023 A start pulse in any state other than IDLE SHALL be ignored.
REQ-024 WAIT: rx_ready=1, cpu_hold=1, busy=1, bus_oe=0.
REQ-025 WAIT with rx_valid=1: latch rx_data into the byte register, clear the timer and go to ADDR.
REQ-026 WAIT without a byte: increment the timer.
REQ-027 If TIMEOUT>0 and the timer reaches TIMEOUT-1 in WAIT without a byte, the next state SHALL be ERR.
REQ-028 ADDR: bus_oe=1, bus_out = zero-extended addr, MI=1; stay for exactly 1 cycle, then go to DATA.
REQ-029 DATA: bus_oe=1, bus_out = latched byte, RI=1; stay for exactly 1 cycle.
REQ-030 DATA exit when addr = LEN-1: go to FIN.
REQ-031 DATA exit otherwise: addr increments by 1 (no wrap within a run) and state returns to WAIT.
REQ-032 MI and RI SHALL never be asserted in the same cycle, and bus_oe SHALL be 1 whenever either is asserted.
REQ-033 Per-byte latency: handshake in cycle N gives MI in N+1, RI in N+2 and rx_ready=1 again in N+3 (at most 1 byte per 3 cycles).
REQ-034 FIN: cpu_hold=1, busy=1 for 1 cycle; then set done and go to IDLE.
REQ-035 ERR: cpu_hold=1, busy=1 for 1 cycle; then set error and go to IDLE; RAM bytes already written are left as-is.
REQ-036 done and error SHALL be mutually exclusive and hold until the next accepted start or rst.

Reset
REQ-037 rst=1 SHALL force IDLE, addr=0, timer=0, byte register=0, done=0, error=0 and all outputs 0 on the next edge.
REQ-038 rst SHALL take priority over start, over rx handshakes and over any mid-run state, including ADDR/DATA.
REQ-039 An interrupted write SHALL not complete after rst deasserts.

Verification
REQ-040 LEN=4: start, then bytes 0x1E,0x2F,0xE0,0xF0 each with rx_valid=1 -> MI cycles carry bus 0x00..0x03, RI cycles carry the bytes in order; done=1, cpu_hold=0 after FIN.
REQ-041 rx_valid held high continuously -> handshakes exactly every 3 cycles; rx_ready=0 in ADDR/DATA.
REQ-042 TIMEOUT=8, LEN=4: 2 bytes, then silence -> ERR after 8 WAIT cycles; error=1, done=0, addr=2, no further MI/RI.
REQ-043 start pulsed during WAIT and during DATA -> no effect: addr is not cleared and the sequence is unchanged.
REQ-044 rst asserted in the ADDR cycle of byte 3 -> next cycle IDLE, all outputs 0, no RI ever issued for byte 3; a new start then loads from addr 0.
REQ-045 TIMEOUT=0 with a 10,000-cycle gap between bytes -> no error; run completes with done=1.
